// File: rtl/cpu_ad48_trap_unit.sv
// Trap controller for the cpu_ad48 core: arbitrates exceptions, interrupts and MRET,
// maintains the trap CSRs and nesting depth, and issues a one-cycle pipeline redirect.
module cpu_ad48_trap_unit #(
   parameter int               XLEN        = 48,
   parameter int               NUM_IRQ     = 4,
   parameter logic [XLEN-1:0]  TRAP_VECTOR = 48'd32,
   parameter bit               VECTORED    = 1'b0,
   parameter int               MAX_NEST    = 2
) (
   input  logic                clk,
   input  logic                rst,
   input  logic [15:0]         exc_vec,
   input  logic                exc_commit,
   input  logic [XLEN-1:0]     exc_pc,
   input  logic [XLEN-1:0]     exc_tval,
   input  logic [XLEN-1:0]     next_pc,
   input  logic [NUM_IRQ-1:0]  irq,
   input  logic                mret,
   input  logic                csr_we,
   input  logic [2:0]          csr_addr,
   input  logic [XLEN-1:0]     csr_wdata,
   output logic [XLEN-1:0]     csr_rdata,
   output logic                redirect_valid,
   output logic [XLEN-1:0]     redirect_pc,
   output logic [1:0]          priv_mode,
   output logic                halt
);

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_REDIR = 2'd1,
      ST_HALT  = 2'd2
   } state_t;

   state_t              state_q, state_d;
   logic [1:0]          priv_q, priv_d;
   logic                mie_q, mie_d;
   logic [1:0]          ppriv_q, ppriv_d;
   logic                pie_q, pie_d;
   logic [XLEN-1:0]     epc_q, epc_d;
   logic [XLEN-1:0]     cause_q, cause_d;
   logic [XLEN-1:0]     tval_q, tval_d;
   logic [XLEN-1:0]     tvec_q, tvec_d;
   logic [NUM_IRQ-1:0]  ie_q, ie_d;
   logic [2:0]          depth_q, depth_d;
   logic                redirect_valid_q, redirect_valid_d;
   logic [XLEN-1:0]     redirect_pc_q, redirect_pc_d;
   logic                halt_q, halt_d;

   logic                idle_s;
   logic                exc_take_s;
   logic                irq_take_s;
   logic                mret_take_s;
   logic                trap_s;
   logic                nest_full_s;
   logic                csr_wr_s;
   logic [NUM_IRQ-1:0]  irq_pend_s;
   logic [3:0]          exc_code_s;
   logic [2:0]          irq_code_s;
   logic [XLEN-1:0]     trap_cause_s;
   logic [XLEN-1:0]     trap_target_s;

   function automatic logic [3:0] lowest_exc(input logic [15:0] v);
      logic [3:0] r;
      r = 4'd0;
      for (int i = 15; i >= 0; i--) begin
         if (v[i]) begin
            r = 4'(i);
         end else begin
            r = r;
         end
      end
      return r;
   endfunction

   function automatic logic [2:0] lowest_irq(input logic [NUM_IRQ-1:0] v);
      logic [2:0] r;
      r = 3'd0;
      for (int i = NUM_IRQ - 1; i >= 0; i--) begin
         if (v[i]) begin
            r = 3'(i);
         end else begin
            r = r;
         end
      end
      return r;
   endfunction

   // Arbitration: exception beats interrupt beats mret, and only in IDLE.
   always_comb begin
      idle_s        = (state_q == ST_IDLE);
      irq_pend_s    = irq & ie_q;
      exc_take_s    = idle_s && exc_commit && (|exc_vec);
      irq_take_s    = idle_s && !exc_take_s && mie_q && (|irq_pend_s);
      mret_take_s   = idle_s && !exc_take_s && !irq_take_s && mret;
      trap_s        = exc_take_s || irq_take_s;
      nest_full_s   = (depth_q == 3'(MAX_NEST));
      csr_wr_s      = csr_we && (state_q != ST_HALT) && !(trap_s && nest_full_s);
      exc_code_s    = lowest_exc(exc_vec);
      irq_code_s    = lowest_irq(irq_pend_s);
      if (exc_take_s) begin
         trap_cause_s = XLEN'(exc_code_s);
      end else begin
         trap_cause_s = {1'b1, (XLEN-1)'(irq_code_s)};
      end
      if (VECTORED && irq_take_s) begin
         trap_target_s = tvec_q + XLEN'(irq_code_s);
      end else begin
         trap_target_s = tvec_q;
      end
   end

   // Next-state: software CSR writes first, hardware trap/mret updates override them.
   always_comb begin
      state_d          = state_q;
      priv_d           = priv_q;
      mie_d            = mie_q;
      ppriv_d          = ppriv_q;
      pie_d            = pie_q;
      epc_d            = epc_q;
      cause_d          = cause_q;
      tval_d           = tval_q;
      tvec_d           = tvec_q;
      ie_d             = ie_q;
      depth_d          = depth_q;
      redirect_valid_d = 1'b0;
      redirect_pc_d    = redirect_pc_q;
      halt_d           = halt_q;

      if (csr_wr_s) begin
         case (csr_addr)
            3'd0: begin
               priv_d  = csr_wdata[1:0];
               mie_d   = csr_wdata[2];
               ppriv_d = csr_wdata[4:3];
               pie_d   = csr_wdata[5];
            end
            3'd1:    epc_d   = csr_wdata;
            3'd2:    cause_d = csr_wdata;
            3'd3:    tval_d  = csr_wdata;
            3'd4:    tvec_d  = csr_wdata;
            3'd5:    ie_d    = csr_wdata[NUM_IRQ-1:0];
            default: ie_d    = ie_q;
         endcase
      end else begin
         ie_d = ie_q;
      end

      case (state_q)
         ST_IDLE: begin
            if (trap_s && nest_full_s) begin
               halt_d  = 1'b1;
               state_d = ST_HALT;
            end else if (trap_s) begin
               ppriv_d          = priv_q;
               pie_d            = mie_q;
               mie_d            = 1'b0;
               priv_d           = 2'd3;
               cause_d          = trap_cause_s;
               epc_d            = exc_take_s ? exc_pc : next_pc;
               tval_d           = exc_take_s ? exc_tval : {XLEN{1'b0}};
               depth_d          = depth_q + 3'd1;
               redirect_valid_d = 1'b1;
               redirect_pc_d    = trap_target_s;
               state_d          = ST_REDIR;
            end else if (mret_take_s) begin
               priv_d           = ppriv_q;
               mie_d            = pie_q;
               pie_d            = 1'b1;
               ppriv_d          = 2'd0;
               depth_d          = (depth_q != 3'd0) ? (depth_q - 3'd1) : 3'd0;
               redirect_valid_d = 1'b1;
               redirect_pc_d    = epc_q;
               state_d          = ST_REDIR;
            end else begin
               state_d = ST_IDLE;
            end
         end
         ST_REDIR: state_d = ST_IDLE;
         ST_HALT: begin
            halt_d  = 1'b1;
            state_d = ST_HALT;
         end
         default: state_d = ST_IDLE;
      endcase
   end

   // State and CSR registers with synchronous reset.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q          <= ST_IDLE;
         priv_q           <= 2'd3;
         mie_q            <= 1'b0;
         ppriv_q          <= 2'd0;
         pie_q            <= 1'b0;
         epc_q            <= {XLEN{1'b0}};
         cause_q          <= {XLEN{1'b0}};
         tval_q           <= {XLEN{1'b0}};
         tvec_q           <= TRAP_VECTOR;
         ie_q             <= {NUM_IRQ{1'b0}};
         depth_q          <= 3'd0;
         redirect_valid_q <= 1'b0;
         redirect_pc_q    <= {XLEN{1'b0}};
         halt_q           <= 1'b0;
      end else begin
         state_q          <= state_d;
         priv_q           <= priv_d;
         mie_q            <= mie_d;
         ppriv_q          <= ppriv_d;
         pie_q            <= pie_d;
         epc_q            <= epc_d;
         cause_q          <= cause_d;
         tval_q           <= tval_d;
         tvec_q           <= tvec_d;
         ie_q             <= ie_d;
         depth_q          <= depth_d;
         redirect_valid_q <= redirect_valid_d;
         redirect_pc_q    <= redirect_pc_d;
         halt_q           <= halt_d;
      end
   end

   // CSR read mux; unimplemented STATUS bits and unused addresses read as zero.
   always_comb begin
      case (csr_addr)
         3'd0:    csr_rdata = {{(XLEN-6){1'b0}}, pie_q, ppriv_q, mie_q, priv_q};
         3'd1:    csr_rdata = epc_q;
         3'd2:    csr_rdata = cause_q;
         3'd3:    csr_rdata = tval_q;
         3'd4:    csr_rdata = tvec_q;
         3'd5:    csr_rdata = XLEN'(ie_q);
         3'd6:    csr_rdata = XLEN'(depth_q);
         default: csr_rdata = {XLEN{1'b0}};
      endcase
   end

   assign redirect_valid = redirect_valid_q;
   assign redirect_pc    = redirect_pc_q;
   assign priv_mode      = priv_q;
   assign halt           = halt_q;

endmodule
